// File: rtl/jesd204_lane_latency_checker_if.sv
// Bundle between the JESD204 lane latency checker and its controller / register map.
// Handshake: a one-cycle start is accepted only while the checker is idle or done; results are valid while done is high.
interface jesd204_lane_latency_checker_if #(
  parameter int NUM_LANES     = 1,
  parameter int TIMEOUT_WIDTH = 16
);
  logic                       start;
  logic [NUM_LANES-1:0]       cfg_lanes_disable;
  logic [13:0]                cfg_max_spread;
  logic [TIMEOUT_WIDTH-1:0]   cfg_timeout;
  logic [14*NUM_LANES-1:0]    lane_latency;
  logic [NUM_LANES-1:0]       lane_latency_ready;

  logic                       busy;
  logic                       done;
  logic                       timeout;
  logic [NUM_LANES-1:0]       lane_missing;
  logic [13:0]                latency_min;
  logic [13:0]                latency_max;
  logic [13:0]                latency_spread;
  logic                       spread_error;
  logic [13:0]                spread_watermark;
  logic [2:0]                 dbg_state;

  modport master (
    output start, cfg_lanes_disable, cfg_max_spread, cfg_timeout,
           lane_latency, lane_latency_ready,
    input  busy, done, timeout, lane_missing, latency_min, latency_max,
           latency_spread, spread_error, spread_watermark, dbg_state
  );

  modport slave (
    input  start, cfg_lanes_disable, cfg_max_spread, cfg_timeout,
           lane_latency, lane_latency_ready,
    output busy, done, timeout, lane_missing, latency_min, latency_max,
           latency_spread, spread_error, spread_watermark, dbg_state
  );
endinterface

// File: rtl/jesd204_lane_latency_checker.sv
// Waits for all enabled lanes' latencies, scans them one per cycle and reports min/max/spread.
// Optional JESD204_LATENCY_WATERMARK_EN keeps the worst spread seen since reset.
module jesd204_lane_latency_checker #(
  parameter int NUM_LANES     = 1,
  parameter int TIMEOUT_WIDTH = 16
) (
  input logic                        clk,
  input logic                        resetn,
  jesd204_lane_latency_checker_if.slave bus
);
  localparam int IDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LANES - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_SCAN = 3'd2,
    S_CALC = 3'd3,
    S_DONE = 3'd4
  } state_e;

  state_e                   state_q;
  logic [TIMEOUT_WIDTH-1:0] tmo_cnt_q;
  logic [NUM_LANES-1:0]     scan_mask_q;
  logic [NUM_LANES-1:0]     missing_q;
  logic [IDX_W-1:0]         idx_q;
  logic                     have_q;
  logic                     busy_q;
  logic                     done_q;
  logic                     timeout_q;
  logic                     spread_err_q;
  logic [13:0]              min_q;
  logic [13:0]              max_q;
  logic [13:0]              spread_q;

  logic                     complete_d;
  logic                     tmo_hit_d;
  logic [13:0]              spread_d;
  logic [13:0]              lat_arr [NUM_LANES];

  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      lat_arr[i] = bus.lane_latency[14*i +: 14];
    end
  end

  assign complete_d = &(bus.lane_latency_ready | bus.cfg_lanes_disable);
  // Completion takes priority over a timeout landing on the same cycle.
  assign tmo_hit_d  = (bus.cfg_timeout != '0) &&
                      (tmo_cnt_q == bus.cfg_timeout - TIMEOUT_WIDTH'(1)) && !complete_d;
  assign spread_d   = max_q - min_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      tmo_cnt_q    <= '0;
      scan_mask_q  <= '0;
      missing_q    <= '0;
      idx_q        <= '0;
      have_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      spread_err_q <= 1'b0;
      min_q        <= '0;
      max_q        <= '0;
      spread_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          tmo_cnt_q <= '0;
          if (bus.start) begin
            state_q      <= S_WAIT;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
            spread_err_q <= 1'b0;
            missing_q    <= '0;
            have_q       <= 1'b0;
            min_q        <= '0;
            max_q        <= '0;
            spread_q     <= '0;
          end
        end
        S_WAIT: begin
          if (tmo_cnt_q != '1) tmo_cnt_q <= tmo_cnt_q + TIMEOUT_WIDTH'(1);
          if (complete_d || tmo_hit_d) begin
            state_q     <= S_SCAN;
            timeout_q   <= tmo_hit_d;
            scan_mask_q <= bus.lane_latency_ready & ~bus.cfg_lanes_disable;
            missing_q   <= ~bus.lane_latency_ready & ~bus.cfg_lanes_disable;
            idx_q       <= '0;
          end
        end
        S_SCAN: begin
          // Latencies are sampled live; the monitor holds them once ready.
          if (scan_mask_q[idx_q]) begin
            have_q <= 1'b1;
            if (!have_q) begin
              min_q <= lat_arr[idx_q];
              max_q <= lat_arr[idx_q];
            end else begin
              if (lat_arr[idx_q] < min_q) min_q <= lat_arr[idx_q];
              if (lat_arr[idx_q] > max_q) max_q <= lat_arr[idx_q];
            end
          end
          if (idx_q == LAST_IDX) state_q <= S_CALC;
          else                   idx_q   <= idx_q + IDX_W'(1);
        end
        S_CALC: begin
          spread_q     <= spread_d;
          spread_err_q <= (spread_d > bus.cfg_max_spread);
          busy_q       <= 1'b0;
          done_q       <= 1'b1;
          state_q      <= S_DONE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef JESD204_LATENCY_WATERMARK_EN
  logic [13:0] wm_q;

  // Empty scans leave min/max at 0, so have_q keeps them out of the watermark.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wm_q <= '0;
    end else if (state_q == S_CALC && have_q && spread_d > wm_q) begin
      wm_q <= spread_d;
    end
  end

  assign bus.spread_watermark = wm_q;
`else
  assign bus.spread_watermark = '0;
`endif

  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.timeout        = timeout_q;
  assign bus.lane_missing   = missing_q;
  assign bus.latency_min    = min_q;
  assign bus.latency_max    = max_q;
  assign bus.latency_spread = spread_q;
  assign bus.spread_error   = spread_err_q;
  assign bus.dbg_state      = state_q;
endmodule

// File: tb/tb_jesd204_lane_latency_checker.sv
// Bench for jesd204_lane_latency_checker: per-run plans are turned into expected results and
// expected cycle timing by plain arithmetic, then compared against the DUT on every cycle.
module tb_jesd204_lane_latency_checker;
  localparam int N     = 4;
  localparam int TW    = 16;
  localparam int RW    = 48;
  localparam int NEVER = 100000;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  jesd204_lane_latency_checker_if #(.NUM_LANES(N), .TIMEOUT_WIDTH(TW)) bus ();

  jesd204_lane_latency_checker #(.NUM_LANES(N), .TIMEOUT_WIDTH(TW)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit check_en = 1'b0;

  // Run plan
  logic [13:0]   p_lat [N];
  int            p_rel [N];
  logic [N-1:0]  p_dis;
  logic [13:0]   p_ms;
  logic [TW-1:0] p_tmo;
  int            run_t;
  bit            poke_start;

  // Expected behaviour of the current run
  bit            run_active = 1'b0;
  int            m_t, m_s, m_dc;
  logic          m_tmo;
  logic [N-1:0]  m_miss;
  logic [13:0]   m_min, m_max, m_spread;
  logic          m_err;
  logic [13:0]   wm_prev = '0;
  logic [13:0]   wm_cur  = '0;
  logic [RW-1:0] exp_q [$];
  logic [RW-1:0] cur_res;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic drive_ready();
    for (int i = 0; i < N; i++) bus.lane_latency_ready[i] = (cyc >= run_t + p_rel[i]);
  endtask

  task automatic launch();
    int maxr, w_rel, s_rel;
    bit any, tmo;
    logic [N-1:0] miss;
    logic [13:0] lo, hi, spr;
    bus.cfg_lanes_disable = p_dis;
    bus.cfg_max_spread    = p_ms;
    bus.cfg_timeout       = p_tmo;
    for (int i = 0; i < N; i++) bus.lane_latency[14*i +: 14] = p_lat[i];
    run_t = cyc;
    drive_ready();
    bus.start = 1'b1;
    // WAIT ends at the first cycle all enabled lanes are ready, or after cfg_timeout cycles.
    maxr = 0;
    for (int i = 0; i < N; i++) if (!p_dis[i] && p_rel[i] > maxr) maxr = p_rel[i];
    w_rel = (maxr < 1) ? 1 : maxr;
    if (p_tmo != 0 && w_rel > int'(p_tmo)) begin
      s_rel = int'(p_tmo);
      tmo   = 1'b1;
    end else begin
      s_rel = w_rel;
      tmo   = 1'b0;
    end
    any = 1'b0; lo = '0; hi = '0; miss = '0;
    for (int i = 0; i < N; i++) begin
      if (!p_dis[i] && p_rel[i] > s_rel) miss[i] = 1'b1;
      if (!p_dis[i] && p_rel[i] <= s_rel) begin
        if (!any) begin lo = p_lat[i]; hi = p_lat[i]; end
        else begin
          if (p_lat[i] < lo) lo = p_lat[i];
          if (p_lat[i] > hi) hi = p_lat[i];
        end
        any = 1'b1;
      end
    end
    spr = hi - lo;
    @(posedge clk); #1;
    bus.start = 1'b0;
    m_t = run_t; m_s = run_t + s_rel; m_dc = m_s + N + 2;
    m_tmo = tmo; m_miss = miss; m_min = lo; m_max = hi; m_spread = spr;
    m_err = (spr > p_ms);
    wm_prev = wm_cur;
`ifdef JESD204_LATENCY_WATERMARK_EN
    if (any && spr > wm_cur) wm_cur = spr;
`endif
    exp_q.push_back({tmo, miss, lo, hi, spr, m_err});
    run_active = 1'b1;
  endtask

  task automatic step_until(input int c_end);
    while (cyc < c_end) begin
      drive_ready();
      bus.start = poke_start && cyc > m_t && cyc < m_dc && ($urandom_range(0, 3) == 0);
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    drive_ready();
  endtask

  task automatic run_case(input int hold);
    launch();
    step_until(m_dc + hold);
  endtask

  // Per-cycle compare against the run model
  always @(negedge clk) begin
    if (check_en) begin
      if (!run_active) begin
        chk("idle_busy", bus.busy, 0);
        chk("idle_done", bus.done, 0);
        chk("idle_timeout", bus.timeout, 0);
        chk("idle_missing", bus.lane_missing, 0);
        chk("idle_min", bus.latency_min, 0);
        chk("idle_max", bus.latency_max, 0);
        chk("idle_spread", bus.latency_spread, 0);
        chk("idle_err", bus.spread_error, 0);
        chk("idle_wm", bus.spread_watermark, wm_cur);
        chk("idle_state", bus.dbg_state, 0);
      end else begin
        chk("busy", bus.busy, (cyc > m_t && cyc < m_dc));
        chk("done", bus.done, (cyc >= m_dc));
        if (cyc == m_dc) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL result_word cyc=%0d actual=no_entry expected=queued_result", cyc);
          end else begin
            cur_res = exp_q.pop_front();
            chk("result_word", {bus.timeout, bus.lane_missing, bus.latency_min, bus.latency_max,
                                bus.latency_spread, bus.spread_error}, cur_res);
          end
        end
        if (cyc >= m_dc) begin
          chk("timeout", bus.timeout, m_tmo);
          chk("missing", bus.lane_missing, m_miss);
          chk("min", bus.latency_min, m_min);
          chk("max", bus.latency_max, m_max);
          chk("spread", bus.latency_spread, m_spread);
          chk("err", bus.spread_error, m_err);
          chk("wm", bus.spread_watermark, wm_cur);
        end else begin
          chk("run_timeout", bus.timeout, (cyc > m_s) ? m_tmo : 1'b0);
          chk("run_missing", bus.lane_missing, (cyc > m_s) ? m_miss : '0);
          chk("run_spread", bus.latency_spread, 0);
          chk("run_err", bus.spread_error, 0);
          chk("run_wm", bus.spread_watermark, wm_prev);
          if (cyc <= m_s) begin
            chk("run_min", bus.latency_min, 0);
            chk("run_max", bus.latency_max, 0);
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic set_lat(input int a, input int b, input int c, input int d);
    p_lat[0] = 14'(a); p_lat[1] = 14'(b); p_lat[2] = 14'(c); p_lat[3] = 14'(d);
  endtask

  initial begin
    logic [13:0] wm_lit;
    bus.start = 1'b0;
    bus.cfg_lanes_disable = '0;
    bus.cfg_max_spread = '0;
    bus.cfg_timeout = '0;
    bus.lane_latency = '0;
    bus.lane_latency_ready = '0;
    poke_start = 1'b0;
    run_t = 0;
    for (int i = 0; i < N; i++) p_rel[i] = 0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    check_en = 1'b1;
    chk("reset_done", bus.done, 0);
    chk("reset_min", bus.latency_min, 0);
    repeat (2) begin @(posedge clk); #1; end

    // Basic run: all lanes ready
    set_lat(100, 104, 98, 101);
    p_dis = '0; p_ms = 14'd8; p_tmo = '0;
    run_case(3);
    chk("t1_min", bus.latency_min, 98);
    chk("t1_max", bus.latency_max, 104);
    chk("t1_spread", bus.latency_spread, 6);
    chk("t1_err", bus.spread_error, 0);
    chk("t1_done_latency", m_dc - m_t, 7);

    // Tighter limit, restarted from DONE
    p_ms = 14'd5;
    launch();
    chk("t2_cleared_done", bus.done, 0);
    chk("t2_cleared_spread", bus.latency_spread, 0);
    step_until(m_dc + 2);
    chk("t2_spread", bus.latency_spread, 6);
    chk("t2_err", bus.spread_error, 1);
    chk("t2_done_latency", m_dc - m_t, 7);

    // Lane 2 never ready, timeout 20
    p_ms = 14'd8; p_tmo = 16'd20; p_rel[2] = NEVER;
    run_case(2);
    chk("t3_wait_len", m_s - m_t, 20);
    chk("t3_timeout", bus.timeout, 1);
    chk("t3_missing", bus.lane_missing, 4'b0100);
    chk("t3_min", bus.latency_min, 100);
    chk("t3_max", bus.latency_max, 104);
    p_rel[2] = 0; p_tmo = '0;

    // Spread 3 after spread 6
    set_lat(100, 103, 101, 102);
    run_case(2);
    chk("t4_spread", bus.latency_spread, 3);
`ifdef JESD204_LATENCY_WATERMARK_EN
    wm_lit = 14'd6;
`else
    wm_lit = 14'd0;
`endif
    chk("t4_watermark", bus.spread_watermark, wm_lit);

    // All lanes disabled
    p_dis = 4'b1111;
    run_case(2);
    chk("t5_done_latency", m_dc - m_t, 7);
    chk("t5_min", bus.latency_min, 0);
    chk("t5_max", bus.latency_max, 0);
    chk("t5_missing", bus.lane_missing, 0);
    chk("t5_err", bus.spread_error, 0);
    p_dis = '0;

    // Reset in the middle of SCAN
    set_lat(100, 104, 98, 101);
    launch();
    repeat (2) begin drive_ready(); @(posedge clk); #1; end
    check_en = 1'b0;
    resetn = 1'b0;
    @(posedge clk); #1;
    run_active = 1'b0;
    wm_cur = '0; wm_prev = '0;
    exp_q.delete();
    resetn = 1'b1;
    check_en = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    chk("t6_done_stays_low", bus.done, 0);
    chk("t6_state_idle", bus.dbg_state, 0);

    // Randomised runs
    poke_start = 1'b1;
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 9) == 0)      p_lat[i] = ($urandom_range(0, 1) == 1) ? 14'h3FFF : 14'h0;
        else if ($urandom_range(0, 3) == 0) p_lat[i] = 14'($urandom);
        else                                p_lat[i] = 14'(1000 + $urandom_range(0, 40));
        p_rel[i] = $urandom_range(0, 12);
        p_dis[i] = ($urandom_range(0, 5) == 0);
      end
      p_tmo = ($urandom_range(0, 2) == 0) ? '0 : TW'($urandom_range(1, 15));
      if (p_tmo != 0 && $urandom_range(0, 2) == 0) p_rel[$urandom_range(0, N-1)] = NEVER;
      p_ms = ($urandom_range(0, 4) == 0) ? 14'($urandom) : 14'($urandom_range(0, 50));
      run_case($urandom_range(0, 3));
    end
    poke_start = 1'b0;

    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
